// File: rtl/cfg_bus_master.sv
// Register-bus initiator. It takes one command at a time, strobes one responder,
// and waits a fixed latency to capture read data. It then returns a response.
module cfg_bus_master #(
    parameter int NUM_TGT = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int TGT_W   = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [TGT_W-1:0]          cmd_tgt,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_TGT-1:0]        io_wr_en,
    output logic [NUM_TGT-1:0]        io_rd_en,
    output logic [ADDR_W-1:0]         io_address,
    output logic [DATA_W-1:0]         io_write_data,
    input  logic [NUM_TGT*DATA_W-1:0] io_read_data
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_n;
    logic               alive;
    logic               wr_q;
    logic [TGT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt;
    logic               tgt_ok;
    logic               cmd_hs;
    logic [DATA_W-1:0]  rd_slice;

    function automatic logic [NUM_TGT-1:0] onehot(input logic [TGT_W-1:0] t);
        logic [NUM_TGT-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (int'(t) == k) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign tgt_ok    = int'(tgt_q) < NUM_TGT;
    // alive keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = (state == IDLE) && alive;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RESP);

    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (int'(tgt_q) == k) rd_slice = io_read_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_hs) state_n = ISSUE;
            ISSUE:   state_n = (wr_q || !tgt_ok) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            alive         <= 1'b0;
            wr_q          <= 1'b0;
            tgt_q         <= '0;
            cnt           <= '0;
            io_wr_en      <= '0;
            io_rd_en      <= '0;
            io_address    <= '0;
            io_write_data <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state    <= state_n;
            alive    <= 1'b1;
            io_wr_en <= '0;
            io_rd_en <= '0;
            if (cmd_hs) begin
                wr_q          <= cmd_write;
                tgt_q         <= cmd_tgt;
                io_address    <= cmd_addr;
                io_write_data <= cmd_wdata;
                // strobe goes out in the ISSUE cycle; out-of-range decodes to none
                if (cmd_write) io_wr_en <= onehot(cmd_tgt);
                else           io_rd_en <= onehot(cmd_tgt);
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(RD_LAT);
                if (wr_q || !tgt_ok) begin
                    rsp_rdata <= '0;
                    rsp_err   <= !tgt_ok;
                end
            end
            if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rsp_rdata <= rd_slice;
                    rsp_err   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Scoreboard bench for cfg_bus_master with three responders and read latency 2.
// Each responder model is a small register file that returns data RD_LAT cycles after its strobe.
module tb_cfg_bus_master;

    localparam int NT = 3;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int TW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [TW-1:0]    cmd_tgt;
    logic [AW-1:0]    cmd_addr;
    logic [DW-1:0]    cmd_wdata;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]    rsp_rdata;
    logic [NT-1:0]    io_wr_en, io_rd_en;
    logic [AW-1:0]    io_address;
    logic [DW-1:0]    io_write_data;
    logic [NT*DW-1:0] io_read_data;

    cfg_bus_master #(.NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .TGT_W(TW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_tgt(cmd_tgt), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_wr_en(io_wr_en), .io_rd_en(io_rd_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Responder models: register file, read data valid only in the cycle RL after the strobe
    logic [DW-1:0] regs [NT][16];
    logic [NT-1:0] rd1 = '0;
    logic [NT-1:0] rd2 = '0;
    logic [AW-1:0] a1 [NT];
    logic [AW-1:0] a2 [NT];
    logic          init_done = 1'b0;

    always @(posedge clock) begin
        if (!init_done) begin
            for (int k = 0; k < NT; k++)
                for (int a = 0; a < 16; a++) regs[k][a] <= 8'h80 ^ 8'(k * 16 + a);
            regs[1][15] <= 8'h3C;
            init_done   <= 1'b1;
        end else begin
            for (int k = 0; k < NT; k++)
                if (io_wr_en[k]) regs[k][io_address] <= io_write_data;
        end
        for (int k = 0; k < NT; k++) begin
            a1[k] <= io_address;
            a2[k] <= a1[k];
        end
        rd1 <= io_rd_en;
        rd2 <= rd1;
    end

    always_comb begin
        io_read_data = '0;
        for (int k = 0; k < NT; k++)
            io_read_data[k*DW +: DW] = rd2[k] ? regs[k][a2[k]] : 8'hEE;
    end

    typedef struct {
        logic [NT-1:0] wr;
        logic [NT-1:0] rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } stb_t;
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    stb_t stb_q[$];
    rsp_t rsp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: strobes, response timing, stability under stall, response contents
    logic          prev_v = 1'b0;
    logic [DW-1:0] held_rdata;
    logic          held_err;

    always @(negedge clock) begin
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if ((io_wr_en | io_rd_en) != '0) begin
                if (stb_q.size() == 0) begin
                    chk("unexpected strobe", {io_wr_en, io_rd_en}, '0);
                end else begin
                    stb_t e;
                    e = stb_q.pop_front();
                    chk("strobe bus", {io_wr_en, io_rd_en, io_address, io_write_data},
                        {e.wr, e.rd, e.addr, e.wdata});
                    chk("strobe cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (rsp_valid && !prev_v) begin
                held_rdata = rsp_rdata;
                held_err   = rsp_err;
                if (rsp_q.size() == 0) chk("unexpected rsp_valid", 64'(rsp_valid), 64'(0));
                else                   chk("rsp_valid rise cycle", 64'(cyc), 64'(rsp_q[0].cyc));
            end
            if (rsp_valid && prev_v) begin
                chk("held response", {rsp_rdata, rsp_err}, {held_rdata, held_err});
                chk("cmd_ready during response", 64'(cmd_ready), 64'(0));
            end
            if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
            end
            prev_v = rsp_valid;
        end
    end

    // Issue one command; m is the hand-computed strobe mask (0 = no strobe expected)
    task automatic send(input logic w, input logic [TW-1:0] t, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NT-1:0] m,
                        input logic [DW-1:0] erd, input logic eerr, input logic hold,
                        output int tacc);
        int n;
        @(negedge clock);
        cmd_write = w; cmd_tgt = t; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            chk("command accept timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
            tacc = -1;
            return;
        end
        tacc = cyc;
        if (m != '0) stb_q.push_back('{w ? m : '0, w ? '0 : m, a, d, cyc + 1});
        rsp_q.push_back('{erd, eerr, cyc + ((w || eerr) ? 2 : 2 + RL)});
        @(posedge clock);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0) && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("drain queues empty", 64'(rsp_q.size() + stb_q.size()), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, " strobes"}, {io_wr_en, io_rd_en}, '0);
        chk({tag, " io_address"}, 64'(io_address), 64'(0));
        chk({tag, " io_write_data"}, 64'(io_write_data), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb2, tprev, n;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_tgt = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock);
        #1 chk("cmd_ready after release", 64'(cmd_ready), 64'(1));

        send(1, 2, 4'h5, 8'hA7, 3'b100, 8'h00, 0, 0, ta);   // write hit
        send(0, 1, 4'hF, 8'h00, 3'b010, 8'h3C, 0, 0, ta);   // read, latency 2
        send(0, 3, 4'h7, 8'h00, 3'b000, 8'h00, 1, 0, ta);   // read, out of range
        send(1, 0, 4'h3, 8'h5A, 3'b001, 8'h00, 0, 0, ta);
        send(0, 0, 4'h3, 8'h00, 3'b001, 8'h5A, 0, 0, ta);
        send(0, 2, 4'h5, 8'h00, 3'b100, 8'hA7, 0, 0, ta);
        send(1, 3, 4'h1, 8'hFF, 3'b000, 8'h00, 1, 0, ta);   // write, out of range
        drain();

        // Backpressure: response held 5 cycles, next command waiting with cmd_valid high
        rsp_ready = 1'b0;
        send(1, 1, 4'h2, 8'h11, 3'b010, 8'h00, 0, 1, ta);
        fork
            send(0, 1, 4'h2, 8'h00, 3'b010, 8'h11, 0, 0, tb2);
            begin
                n = 0;
                while (!rsp_valid && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall cmd_ready", 64'(cmd_ready), 64'(0));
                    @(negedge clock);
                end
                rsp_ready = 1'b1;
            end
        join
        chk("accept after stall", 64'(tb2 - ta), 64'(8));
        drain();

        // Back-to-back writes, tgt 3 is out of range
        send(1, 3, 4'h8, 8'hC0, 3'b000, 8'h00, 1, 0, tprev);
        send(1, 0, 4'h9, 8'hC1, 3'b001, 8'h00, 0, 0, ta);
        chk("b2b spacing 1", 64'(ta - tprev), 64'(3));
        tprev = ta;
        send(1, 1, 4'hA, 8'hC2, 3'b010, 8'h00, 0, 0, ta);
        chk("b2b spacing 2", 64'(ta - tprev), 64'(3));
        tprev = ta;
        send(1, 2, 4'hB, 8'hC3, 3'b100, 8'h00, 0, 0, ta);
        chk("b2b spacing 3", 64'(ta - tprev), 64'(3));
        drain();
        repeat (4) @(negedge clock);
        chk("bus address persists", 64'(io_address), 64'(4'hB));
        chk("bus data persists", 64'(io_write_data), 64'(8'hC3));

        // Reset during WAIT of a read
        send(0, 0, 4'h3, 8'h00, 3'b001, 8'h5A, 0, 0, ta);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("mid-read reset");
        rsp_q.delete();
        stb_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("cmd_ready held in reset", 64'(cmd_ready), 64'(0));
        reset = 1'b1;
        @(posedge clock);
        #1 chk("cmd_ready after mid reset", 64'(cmd_ready), 64'(1));
        repeat (8) begin
            @(negedge clock);
            chk("no stale rsp_valid", 64'(rsp_valid), 64'(0));
        end

        send(0, 1, 4'h2, 8'h00, 3'b010, 8'h11, 0, 0, ta);
        send(0, 2, 4'hB, 8'h00, 3'b100, 8'hC3, 0, 0, ta);
        drain();
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_bus_master.md
# cfg_bus_master

Register-bus initiator that drives the `io_wr_en` / `io_rd_en` / `io_address` / `io_write_data` / `io_read_data` port group of the configuration sub-modules instantiated under the configure top. It accepts one access command at a time on a valid/ready command channel and steers it to one of `NUM_TGT` responders. It issues a single-cycle write or read strobe, captures read data after a fixed responder latency, and returns a response on a valid/ready response channel. It is the upstream end of every responder's register port.

## Interface
Parameters:
- `NUM_TGT`, 4: number of responders; must be ≥1.
- `ADDR_W`, 4: register address width.
- `DATA_W`, 8: register data width.
- `RD_LAT`, 1: cycles from the read-strobe cycle to responder read data being valid; must be ≥1.
- `TGT_W`, `$clog2(NUM_TGT)` (minimum 1): target-select width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_tgt` in `TGT_W`: responder index.
- `cmd_addr` in `ADDR_W`: register address.
- `cmd_wdata` in `DATA_W`: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and errors.
- `rsp_err` out 1: 1 = target index out of range.
- `io_wr_en` out `NUM_TGT`: per-responder write strobe.
- `io_rd_en` out `NUM_TGT`: per-responder read strobe.
- `io_address` out `ADDR_W`: address shared by all responders.
- `io_write_data` out `DATA_W`: write data shared by all responders.
- `io_read_data` in `NUM_TGT*DATA_W`: read data, flattened; responder k occupies bits [k*DATA_W +: DATA_W].

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready` = 1; it is high only in IDLE.
  - On handshake, register `cmd_write`, `cmd_tgt`, `cmd_addr`, `cmd_wdata`, and go to ISSUE.
- ISSUE (exactly one cycle):
  - `io_address` and `io_write_data` are driven from the registered command.
  - For a valid target, exactly one bit of `io_wr_en` (write) or `io_rd_en` (read) is high, at index `cmd_tgt`.
  - For `cmd_tgt` ≥ `NUM_TGT`, no strobe is raised. Set `rsp_err` = 1 and `rsp_rdata` = 0, and go to RESP.
  - A valid write goes to RESP with `rsp_rdata` = 0 and `rsp_err` = 0.
  - A valid read loads the latency counter with `RD_LAT` and goes to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter reads 1, register the slice `io_read_data[cmd_tgt]` into `rsp_rdata` and go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are stable.
  - On `rsp_ready`, go to IDLE.
- `io_address` and `io_write_data` are registered and hold their last issued value between accesses; they are updated only on entry to ISSUE.
- All strobes are registered outputs, free of glitches.
- Only one access is ever in flight; no command is accepted while a response is pending.

## Timing
- Reset values: `cmd_ready` = 0 while reset is asserted and 1 from the first cycle after release. `rsp_valid`, `rsp_err`, `rsp_rdata`, `io_wr_en`, `io_rd_en`, `io_address` and `io_write_data` are all 0. State is IDLE.
- All timing below is for a command accepted at the edge ending cycle T:
  - Strobe is high in cycle T+1.
  - Write or error: `rsp_valid` rises in cycle T+2.
  - Read: responder data is sampled at the edge ending cycle T+1+`RD_LAT`, and `rsp_valid` rises in cycle T+2+`RD_LAT`.
- If `rsp_ready` is already high when `rsp_valid` rises, the response handshakes in that same cycle and `cmd_ready` is high in the next cycle.
- Minimum turnaround is 3 cycles per write and 3+`RD_LAT` cycles per read.
- A `rsp_ready` held low stalls the block indefinitely in RESP. Outputs are held and `cmd_ready` stays 0.
- `cmd_valid` asserted outside IDLE is ignored and must not be lost: the upstream holds it until `cmd_ready`.
- Reset asserted mid-access:
  - Strobes, `rsp_valid` and `cmd_ready` drop to 0 immediately (asynchronously).
  - The in-flight access and any pending response are discarded.
  - The FSM is in IDLE after reset release.
- `rsp_rdata` is only meaningful while `rsp_valid` = 1. It is not cleared on handshake, only reloaded by the next access.

## Test plan
- Write hit: `NUM_TGT`=4, cmd write tgt=2 addr=0x5 data=0xA7 at T.
  - Cycle T+1: `io_wr_en`=4'b0100, `io_address`=0x5, `io_write_data`=0xA7, `io_rd_en`=0.
  - Cycle T+2: `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0x00.
- Read with latency: `RD_LAT`=2; responder 1 drives 0x3C two cycles after its `io_rd_en`; cmd read tgt=1 addr=0xF at T.
  - Cycle T+1: `io_rd_en`=4'b0010.
  - Cycle T+4: `rsp_valid`=1, `rsp_rdata`=0x3C.
- Out-of-range target: `NUM_TGT`=3, cmd read tgt=3.
  - No strobe in any cycle.
  - Cycle T+2: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with `cmd_valid`=1 throughout.
  - `cmd_ready` stays 0 and the response is held stable.
  - One cycle after `rsp_ready`=1 handshakes, `cmd_ready`=1 and the next command is accepted.
- Back-to-back: four writes to tgt 0..3 with `rsp_ready` tied high.
  - Strobes occur exactly once each, 3 cycles apart.
  - The last address/data values persist on the bus afterwards.
- Reset mid-read: assert `reset`=0 during WAIT.
  - All outputs go to their reset values at once.
  - After release, `cmd_ready`=1 and no stale `rsp_valid` appears.
